// File: rtl/risc16_pkg.sv
// ============================================================================
// Module      : risc16_pkg
// Description : Opcodes, ALU codes and control-FSM state encodings shared by
//               the 16-bit multicycle RISC control path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package risc16_pkg;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_JMP   = 4'h5;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;
    localparam logic [2:0] ALU_SLL = 3'd6;
    localparam logic [2:0] ALU_SRL = 3'd7;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    // Opcodes that read operands and go through EXEC.
    function automatic logic op_uses_exec(input logic [3:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
               (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_unit_imm_sign_ext.sv
// ============================================================================
// Module      : imm_sign_ext
// Description : Combinational 6-bit to 16-bit immediate sign extension.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_sign_ext (
    input  logic [5:0]  i_imm6,
    output logic [15:0] o_imm16
);

    assign o_imm16 = {{10{i_imm6[5]}}, i_imm6};

endmodule

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// ============================================================================
// Module      : multicycle_control_unit
// Description : Fetch/decode/sequencing FSM of the 16-bit multicycle RISC core;
//               holds PC and IR. Optional macro ILLEGAL_TRAP_EN traps opcodes
//               6..E, otherwise they execute as NOPs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control_unit
    import risc16_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        alu_zero,
    output logic [15:0] pc,
    output logic [15:0] ir,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [2:0]  rf_aaddr,
    output logic [2:0]  rf_baddr,
    output logic [2:0]  alu_op,
    output logic        alu_src_imm,
    output logic [15:0] imm,
    output logic        wb_sel,
    output logic        halted,
    output logic        illegal
);

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_pc;
    logic [15:0] w_pc_next;
    logic [15:0] r_ir;
    logic [15:0] w_ir_next;
    logic [15:0] w_imm;
    logic [3:0]  w_opcode;
    logic        w_mem_req;
    logic        w_mem_we;
    logic        w_rf_we;

    assign w_opcode = r_ir[15:12];

    imm_sign_ext u_imm_sign_ext (
        .i_imm6  (r_ir[5:0]),
        .o_imm16 (w_imm)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_ir    <= w_ir_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_ir_next    = r_ir;
        case (r_state)
            S_FETCH: begin
                if (mem_ready) begin
                    w_ir_next    = mem_rdata;
                    w_pc_next    = r_pc + 16'd1;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_opcode == OP_JMP) begin
                    w_pc_next    = {r_pc[15:12], r_ir[11:0]};
                    w_state_next = S_FETCH;
                end else if (w_opcode == OP_HALT) begin
                    w_state_next = S_HALT;
                end else if (op_uses_exec(w_opcode)) begin
                    w_state_next = S_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    w_state_next = S_TRAP;
`else
                    w_state_next = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                if (w_opcode == OP_BEQ) begin
                    // pc already points past the branch, so the offset is relative to pc+1
                    if (alu_zero) begin
                        w_pc_next = r_pc + w_imm;
                    end
                    w_state_next = S_FETCH;
                end else if ((w_opcode == OP_LW) || (w_opcode == OP_SW)) begin
                    w_state_next = S_MEM;
                end else begin
                    w_state_next = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    w_state_next = (w_opcode == OP_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB:    w_state_next = S_FETCH;
            S_HALT:  w_state_next = S_HALT;
            S_TRAP:  w_state_next = S_TRAP;
            default: w_state_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_rf_we      = 1'b0;
        mem_addr_sel = 1'b0;
        alu_op       = ALU_ADD;
        alu_src_imm  = 1'b0;
        wb_sel       = 1'b0;
        halted       = 1'b0;
        // ALU controls stay valid through MEM/WB so the address and result hold steady
        if ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB)) begin
            if (w_opcode == OP_RTYPE) begin
                alu_op = r_ir[2:0];
            end else if (w_opcode == OP_BEQ) begin
                alu_op = ALU_SUB;
            end else begin
                alu_op      = ALU_ADD;
                alu_src_imm = 1'b1;
            end
        end
        case (r_state)
            S_FETCH: w_mem_req = 1'b1;
            S_MEM: begin
                w_mem_req    = 1'b1;
                mem_addr_sel = 1'b1;
                w_mem_we     = (w_opcode == OP_SW);
            end
            S_WB: begin
                w_rf_we = 1'b1;
                wb_sel  = (w_opcode == OP_LW);
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    // State resets to FETCH asynchronously, so strobes are masked while rst is held.
    assign mem_req = w_mem_req & ~rst;
    assign mem_we  = w_mem_we & ~rst;
    assign rf_we   = w_rf_we & ~rst;

`ifdef ILLEGAL_TRAP_EN
    assign illegal = (r_state == S_TRAP);
`else
    assign illegal = 1'b0;
`endif

    assign pc       = r_pc;
    assign ir       = r_ir;
    assign imm      = w_imm;
    assign rf_waddr = r_ir[11:9];
    assign rf_aaddr = r_ir[8:6];
    assign rf_baddr = ((w_opcode == OP_SW) || (w_opcode == OP_BEQ)) ? r_ir[11:9] : r_ir[5:3];

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ============================================================================
// Module      : tb_multicycle_control_unit
// Description : Directed self-checking bench for multicycle_control_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control_unit;

    logic        clk;
    logic        rst;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        alu_zero;
    logic [15:0] pc, ir, imm;
    logic        mem_req, mem_we, mem_addr_sel, rf_we, alu_src_imm, wb_sel, halted, illegal;
    logic [2:0]  rf_waddr, rf_aaddr, rf_baddr, alu_op;

    // Secondary instances for high-address jump and PC wrap.
    logic        rst2;
    logic [15:0] rdata2;
    logic [15:0] pc_b, ir_b, imm_b, pc_c, ir_c, imm_c;
    logic        req_b, we_b, sel_b, rfwe_b, src_b, wbs_b, hlt_b, ill_b;
    logic        req_c, we_c, sel_c, rfwe_c, src_c, wbs_c, hlt_c, ill_c;
    logic [2:0]  wa_b, aa_b, ba_b, op_b, wa_c, aa_c, ba_c, op_c;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_control_unit #(.RESET_PC(16'h0010)) u_dut (
        .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .alu_zero(alu_zero),
        .pc(pc), .ir(ir), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_aaddr(rf_aaddr), .rf_baddr(rf_baddr),
        .alu_op(alu_op), .alu_src_imm(alu_src_imm), .imm(imm), .wb_sel(wb_sel),
        .halted(halted), .illegal(illegal)
    );

    multicycle_control_unit #(.RESET_PC(16'h1234)) u_dut_b (
        .clk(clk), .rst(rst2), .mem_rdata(rdata2), .mem_ready(1'b1), .alu_zero(1'b0),
        .pc(pc_b), .ir(ir_b), .mem_req(req_b), .mem_we(we_b), .mem_addr_sel(sel_b),
        .rf_we(rfwe_b), .rf_waddr(wa_b), .rf_aaddr(aa_b), .rf_baddr(ba_b),
        .alu_op(op_b), .alu_src_imm(src_b), .imm(imm_b), .wb_sel(wbs_b),
        .halted(hlt_b), .illegal(ill_b)
    );

    multicycle_control_unit #(.RESET_PC(16'hFFFF)) u_dut_c (
        .clk(clk), .rst(rst2), .mem_rdata(rdata2), .mem_ready(1'b1), .alu_zero(1'b0),
        .pc(pc_c), .ir(ir_c), .mem_req(req_c), .mem_we(we_c), .mem_addr_sel(sel_c),
        .rf_we(rfwe_c), .rf_waddr(wa_c), .rf_aaddr(aa_c), .rf_baddr(ba_c),
        .alu_op(op_c), .alu_src_imm(src_c), .imm(imm_c), .wb_sel(wbs_c),
        .halted(hlt_c), .illegal(ill_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        rst       = 1'b1;
        rst2      = 1'b1;
        mem_rdata = 16'h0000;
        mem_ready = 1'b0;
        alu_zero  = 1'b0;
        rdata2    = 16'h5ABC;

        // Reset values
        step(); step();
        check("rst_pc", pc, 16'h0010);
        check("rst_ir", ir, 16'h0000);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        rst = 1'b0;
        #1;
        check("fetch_req", mem_req, 1'b1);
        check("fetch_sel", mem_addr_sel, 1'b0);

        // ADD r1, r2, r3
        mem_rdata = 16'h0298;
        mem_ready = 1'b1;
        step();
        check("add_ir", ir, 16'h0298);
        check("add_pc", pc, 16'h0011);
        check("add_dec_req", mem_req, 1'b0);
        check("add_dec_we", rf_we, 1'b0);
        step();
        check("add_exec_op", alu_op, 3'd0);
        check("add_exec_src", alu_src_imm, 1'b0);
        check("add_exec_we", rf_we, 1'b0);
        check("add_waddr", rf_waddr, 3'd1);
        check("add_aaddr", rf_aaddr, 3'd2);
        check("add_baddr", rf_baddr, 3'd3);
        step();
        check("add_wb_we", rf_we, 1'b1);
        check("add_wb_sel", wb_sel, 1'b0);
        step();
        check("add_back_we", rf_we, 1'b0);
        check("add_back_req", mem_req, 1'b1);

        // LW r4, 5(r1) with three wait cycles in MEM
        mem_rdata = 16'h2845;
        step();
        check("lw_pc", pc, 16'h0012);
        mem_ready = 1'b0;
        step();
        check("lw_exec_src", alu_src_imm, 1'b1);
        check("lw_exec_op", alu_op, 3'd0);
        check("lw_imm", imm, 16'h0005);
        check("lw_waddr", rf_waddr, 3'd4);
        for (int i = 0; i < 3; i++) begin
            step();
            check("lw_mem_req", mem_req, 1'b1);
            check("lw_mem_we", mem_we, 1'b0);
            check("lw_mem_sel", mem_addr_sel, 1'b1);
        end
        mem_ready = 1'b1;
        step();
        check("lw_wb_we", rf_we, 1'b1);
        check("lw_wb_sel", wb_sel, 1'b1);
        check("lw_wb_req", mem_req, 1'b0);
        step();

        // SW r3 -> mem[r2 + 1]
        mem_rdata = 16'h3681;
        step();
        step();
        check("sw_baddr", rf_baddr, 3'd3);
        check("sw_imm", imm, 16'h0001);
        step();
        check("sw_mem_we", mem_we, 1'b1);
        check("sw_mem_req", mem_req, 1'b1);
        step();
        check("sw_done_sel", mem_addr_sel, 1'b0);
        check("sw_done_we", rf_we, 1'b0);
        check("sw_done_pc", pc, 16'h0013);

        // JMP 0x005, then BEQ -2 taken
        mem_rdata = 16'h5005;
        step(); step();
        check("jmp_pc", pc, 16'h0005);
        mem_rdata = 16'h403E;
        step();
        check("beq_dec_pc", pc, 16'h0006);
        alu_zero = 1'b1;
        step();
        check("beq_exec_op", alu_op, 3'd1);
        check("beq_baddr", rf_baddr, 3'd0);
        step();
        check("beq_taken_pc", pc, 16'h0004);
        check("beq_taken_req", mem_req, 1'b1);

        // Back to 0005, BEQ -2 not taken
        mem_rdata = 16'h5005;
        step(); step();
        mem_rdata = 16'h403E;
        alu_zero  = 1'b0;
        step(); step(); step();
        check("beq_ntaken_pc", pc, 16'h0006);

        // Opcode 7
        mem_rdata = 16'h7000;
        step();
        step();
`ifdef ILLEGAL_TRAP_EN
        check("trap_illegal", illegal, 1'b1);
        check("trap_req", mem_req, 1'b0);
        step();
        check("trap_hold", illegal, 1'b1);
        check("trap_pc", pc, 16'h0007);
`else
        check("nop_pc", pc, 16'h0007);
        check("nop_req", mem_req, 1'b1);
        check("nop_we", rf_we, 1'b0);
        check("nop_illegal", illegal, 1'b0);
        // LW again, reset arrives while waiting in MEM
        mem_rdata = 16'h2845;
        step();
        mem_ready = 1'b0;
        step(); step();
        check("mid_mem_req", mem_req, 1'b1);
        check("mid_mem_sel", mem_addr_sel, 1'b1);
`endif
        rst = 1'b1;
        #1;
        check("rst2_req", mem_req, 1'b0);
        check("rst2_pc", pc, 16'h0010);
        check("rst2_illegal", illegal, 1'b0);
        step();
        rst = 1'b0;
        #1;
        check("rst2_fetch_req", mem_req, 1'b1);
        check("rst2_fetch_sel", mem_addr_sel, 1'b0);

        // HALT is absorbing
        mem_rdata = 16'hF000;
        mem_ready = 1'b1;
        step(); step();
        check("halt_halted", halted, 1'b1);
        check("halt_pc", pc, 16'h0011);
        mem_rdata = 16'h0298;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (halted !== 1'b1 || mem_req !== 1'b0 || rf_we !== 1'b0) bad++;
        end
        check("halt_hold", bad, 0);

        // JMP 0xABC from 0x1234 keeps pc[15:12]; fetch at FFFF wraps
        rst2 = 1'b0;
        step();
        check("hi_dec_pc", pc_b, 16'h1235);
        check("hi_ir", ir_b, 16'h5ABC);
        check("wrap_pc", pc_c, 16'h0000);
        step();
        check("hi_jmp_pc", pc_b, 16'h1ABC);
        check("wrap_jmp_pc", pc_c, 16'h0ABC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
